// File: rtl/alut_apb_master7.sv
// alut_apb_master7: host command port to APB2 initiator for the ALUT bank.
// Supports single read/write and a hardware poll with mask/match and retry budget.
module alut_apb_master7 #(
    parameter int unsigned POLL_MAX = 255,
    parameter int unsigned POLL_GAP = 2
) (
    input  logic        pclk7,
    input  logic        p_reset7,
    input  logic        cmd_valid7,
    output logic        cmd_ready7,
    input  logic [1:0]  cmd_op7,
    input  logic [6:0]  cmd_addr7,
    input  logic [31:0] cmd_wdata7,
    input  logic [31:0] cmd_mask7,
    output logic        rsp_valid7,
    output logic [31:0] rsp_rdata7,
    output logic        rsp_err7,
    output logic        psel7,
    output logic        penable7,
    output logic        pwrite7,
    output logic [6:0]  paddr7,
    output logic [31:0] pwdata7,
    input  logic [31:0] prdata7
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, GAP} state_t;

    localparam logic [1:0] OP_WR   = 2'd1;
    localparam logic [1:0] OP_POLL = 2'd2;
    localparam logic [1:0] OP_ILL  = 2'd3;

    localparam logic [7:0] LAST_CNT = 8'(POLL_MAX);
    localparam logic [3:0] GAP_LAST = 4'(POLL_GAP - 1);

    state_t      state;
    state_t      state_d;
    logic [1:0]  op_q;
    logic [31:0] match_q;
    logic [31:0] mask_q;
    logic [7:0]  cnt_q;
    logic [7:0]  cnt_inc;
    logic [3:0]  gap_q;
    logic        accept;
    logic        hit;
    logic        last;
    logic        done;

    assign cmd_ready7 = (state == IDLE);
    assign accept     = cmd_valid7 && cmd_ready7;
    assign hit        = ((prdata7 ^ match_q) & mask_q) == 32'h0;
    assign cnt_inc    = cnt_q + 8'd1;
    assign last       = (cnt_inc == LAST_CNT);
    assign done       = (op_q != OP_POLL) || hit || last;

    // Next-state decode for the APB phase sequencer
    always_comb begin
        state_d = state;
        unique case (state)
            IDLE: begin
                if (accept && cmd_op7 != OP_ILL)
                    state_d = SETUP;
            end
            SETUP: state_d = ACCESS;
            ACCESS: begin
                if (done)
                    state_d = IDLE;
                else if (POLL_GAP == 0)
                    state_d = SETUP;
                else
                    state_d = GAP;
            end
            GAP: begin
                if (gap_q == GAP_LAST)
                    state_d = SETUP;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge pclk7 or posedge p_reset7) begin
        if (p_reset7)
            state <= IDLE;
        else
            state <= state_d;
    end

    // APB strobes follow the upcoming phase so they are registered
    always_ff @(posedge pclk7 or posedge p_reset7) begin
        if (p_reset7) begin
            psel7    <= 1'b0;
            penable7 <= 1'b0;
        end else begin
            psel7    <= (state_d == SETUP) || (state_d == ACCESS);
            penable7 <= (state_d == ACCESS);
        end
    end

    // Latch the accepted command; APB address/data hold while idle
    always_ff @(posedge pclk7 or posedge p_reset7) begin
        if (p_reset7) begin
            op_q    <= 2'd0;
            match_q <= 32'h0;
            mask_q  <= 32'h0;
            paddr7  <= 7'h0;
            pwdata7 <= 32'h0;
            pwrite7 <= 1'b0;
        end else if (accept && cmd_op7 != OP_ILL) begin
            op_q    <= cmd_op7;
            match_q <= cmd_wdata7;
            mask_q  <= cmd_mask7;
            paddr7  <= cmd_addr7;
            pwrite7 <= (cmd_op7 == OP_WR);
            if (cmd_op7 == OP_WR)
                pwdata7 <= cmd_wdata7;
        end
    end

    // Poll read counter and inter-read gap counter
    always_ff @(posedge pclk7 or posedge p_reset7) begin
        if (p_reset7) begin
            cnt_q <= 8'd0;
            gap_q <= 4'd0;
        end else begin
            if (accept)
                cnt_q <= 8'd0;
            else if (state == ACCESS && !last)
                cnt_q <= cnt_inc;
            if (state == GAP)
                gap_q <= gap_q + 4'd1;
            else
                gap_q <= 4'd0;
        end
    end

    // Completion pulse with read data and error flag
    always_ff @(posedge pclk7 or posedge p_reset7) begin
        if (p_reset7) begin
            rsp_valid7 <= 1'b0;
            rsp_rdata7 <= 32'h0;
            rsp_err7   <= 1'b0;
        end else begin
            rsp_valid7 <= 1'b0;
            if (accept && cmd_op7 == OP_ILL) begin
                rsp_valid7 <= 1'b1;
                rsp_rdata7 <= 32'h0;
                rsp_err7   <= 1'b1;
            end else if (state == ACCESS && done) begin
                rsp_valid7 <= 1'b1;
                rsp_rdata7 <= (op_q == OP_WR) ? 32'h0 : prdata7;
                rsp_err7   <= (op_q == OP_POLL) && !hit;
            end
        end
    end

endmodule

// File: doc/alut_apb_master7.md
# alut_apb_master7

APB initiator that drives the ALUT register bank from a simple host command port. It turns single-cycle host commands into APB2 setup/access transfers (no PREADY), returns read data, and implements a hardware poll: repeated reads of one register until a masked compare matches or a retry budget runs out. It sits between the host-side configuration sequencer and the ALUT APB slave ports.

## Interface
- POLL_MAX, 255: maximum reads issued per poll command (legal 1..255)
- POLL_GAP, 2: idle cycles (psel7=0) between consecutive poll reads (legal 0..15)
- pclk7  in  1  APB clock; all state on rising edge
- p_reset7  in  1  asynchronous, active-high reset
- cmd_valid7  in  1  host command present
- cmd_ready7  out  1  block can accept a command (high only in IDLE)
- cmd_op7  in  2  00 read, 01 write, 10 poll, 11 illegal
- cmd_addr7  in  7  APB register address
- cmd_wdata7  in  32  write data (write); match value (poll)
- cmd_mask7  in  32  compare mask (poll only)
- rsp_valid7  out  1  one-cycle completion pulse, no backpressure
- rsp_rdata7  out  32  read data / last polled data; 0 for write and illegal
- rsp_err7  out  1  poll timeout or illegal op, valid with rsp_valid7
- psel7  out  1  APB select
- penable7  out  1  APB enable
- pwrite7  out  1  APB direction, 1 = write
- paddr7  out  7  APB address
- pwdata7  out  32  APB write data
- prdata7  in  32  APB read data, sampled at end of access cycle

## Operation
- States: IDLE, SETUP, ACCESS, GAP. Reset -> IDLE.
- Accept on cmd_valid7 & cmd_ready7; latch op, addr, wdata, mask; poll counter cleared.
- IDLE -> SETUP for read/write/poll; illegal op stays IDLE, pulses rsp_valid7 next cycle with rsp_err7=1, rsp_rdata7=0.
- SETUP: psel7=1, penable7=0, paddr7/pwrite7/pwdata7 valid and stable through ACCESS. Always -> ACCESS.
- ACCESS: psel7=1, penable7=1; prdata7 captured at the closing edge. Poll counter increments per read.
- Read/write: ACCESS -> IDLE; rsp_valid7=1 next cycle, rsp_err7=0, rsp_rdata7 = captured data (read) or 0 (write).
- Poll: compare (prdata7 & mask) == (match & mask) at closing edge of ACCESS.
  - match -> IDLE, rsp_valid7, rsp_err7=0, rsp_rdata7 = matching data.
  - no match, counter == POLL_MAX -> IDLE, rsp_valid7, rsp_err7=1, rsp_rdata7 = last data.
  - otherwise -> GAP (POLL_GAP cycles, psel7=0, penable7=0), then SETUP; POLL_GAP=0 goes straight to SETUP.
- Poll always issues at least one read; mask 0 matches on the first read.
- paddr7, pwdata7, pwrite7 hold last value when idle; pwrite7=0 for poll reads.
- Poll counter 8 bits, never wraps (bounded by POLL_MAX).

## Timing
- Reset values: cmd_ready7=1 (IDLE), rsp_valid7=0, rsp_rdata7=0, rsp_err7=0, psel7=0, penable7=0, pwrite7=0, paddr7=0, pwdata7=0.
- All outputs registered except cmd_ready7 (decoded from state).
- Accept at edge 0 -> SETUP cycle 1 -> ACCESS cycle 2 -> rsp_valid7 cycle 3; cmd_ready7 high in cycle 3, so next SETUP at cycle 4 earliest. Throughput: one transfer per 3 cycles.
- Poll read spacing: 2 + POLL_GAP cycles between SETUP starts.
- Worst-case poll length: POLL_MAX*(2+POLL_GAP) - POLL_GAP + 1 cycles to response.
- cmd_valid7 while busy ignored (not accepted, not queued).
- p_reset7 mid-transfer: psel7/penable7 drop immediately, no response issued, latched command and poll count discarded.

## Test plan
- Reset with p_reset7 asserted mid-ACCESS -> psel7=penable7=0 same cycle, rsp_valid7 never pulses, cmd_ready7=1 after release.
- Write 0x12345678 to addr 0x04 -> cycle 1 psel7=1 penable7=0 pwrite7=1 paddr7=0x04, cycle 2 penable7=1, cycle 3 rsp_valid7=1 rsp_rdata7=0 rsp_err7=0.
- Read addr 0x30 with slave returning 0xCAFE0001 -> rsp_valid7 cycle 3, rsp_rdata7=0xCAFE0001; back-to-back read accepted in cycle 3 starts SETUP cycle 4.
- Poll addr 0x28 mask 0x2 match 0x0, slave returns 0x2,0x2,0x0 -> three reads each separated by 2 idle cycles, rsp_rdata7=0x0 rsp_err7=0.
- Poll with POLL_MAX=4, never matching, slave returns 0xFF -> exactly 4 access cycles, rsp_err7=1, rsp_rdata7=0xFF.
- Illegal op 11 -> no psel7 activity, rsp_valid7 next cycle with rsp_err7=1 rsp_rdata7=0; cmd_valid7 during busy poll not accepted.
